// File: rtl/arm_mc_controller.sv
// Multicycle control unit for an ARMv4-subset core with a shared memory port.
// A Moore FSM sequences fetch, decode, execute, memory and writeback. The
// unit holds the NZCV flags and gates every architectural write with the
// condition result captured on the way out of DECODE.
module arm_mc_controller (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         AdrSrc,
    output logic         MemWrite,
    output logic         IRWrite,
    output logic         RegWrite,
    output logic [1:0]   ResultSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ALUControl,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic [3:0]   State
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_flags;   // {N,Z,C,V}
    logic        r_condex;

    logic [3:0]  w_cond;
    logic [1:0]  w_op;
    logic [3:0]  w_cmd;
    logic        w_s;
    logic        w_i;
    logic        w_rd_pc;
    logic        w_cond_ok;
    logic [1:0]  w_dp_alu;
    logic        w_dp_valid;
    logic        w_dp_nowrite;
    logic        w_dp_arith;
    logic        w_exec;
    logic        w_unused;

    assign w_cond   = Instr[31:28];
    assign w_op     = Instr[27:26];
    assign w_i      = Instr[25];
    assign w_cmd    = Instr[24:21];
    assign w_s      = Instr[20];
    assign w_rd_pc  = (Instr[15:12] == 4'hF);
    assign w_exec   = (r_state == StExecR) || (r_state == StExecI);
    assign w_unused = ^Instr[19:16];
    assign State    = r_state;

    // Condition check against the registered flags
    always_comb begin
        w_cond_ok = 1'b0;
        case (w_cond)
            4'h0:    w_cond_ok = r_flags[2];
            4'h1:    w_cond_ok = ~r_flags[2];
            4'h2:    w_cond_ok = r_flags[1];
            4'h3:    w_cond_ok = ~r_flags[1];
            4'h4:    w_cond_ok = r_flags[3];
            4'h5:    w_cond_ok = ~r_flags[3];
            4'h6:    w_cond_ok = r_flags[0];
            4'h7:    w_cond_ok = ~r_flags[0];
            4'h8:    w_cond_ok = r_flags[1] & ~r_flags[2];
            4'h9:    w_cond_ok = ~r_flags[1] | r_flags[2];
            4'hA:    w_cond_ok = (r_flags[3] == r_flags[0]);
            4'hB:    w_cond_ok = (r_flags[3] != r_flags[0]);
            4'hC:    w_cond_ok = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'hD:    w_cond_ok = r_flags[2] | (r_flags[3] != r_flags[0]);
            4'hE:    w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    // Data-processing decode: ALU operation, register write suppression, CV update
    always_comb begin
        w_dp_alu     = 2'b00;
        w_dp_valid   = 1'b1;
        w_dp_nowrite = 1'b0;
        w_dp_arith   = 1'b0;
        case (w_cmd)
            4'b0100: begin w_dp_alu = 2'b00; w_dp_arith = 1'b1; end
            4'b0010: begin w_dp_alu = 2'b01; w_dp_arith = 1'b1; end
            4'b0000: w_dp_alu = 2'b10;
            4'b1100: w_dp_alu = 2'b11;
            4'b1010: begin w_dp_alu = 2'b01; w_dp_arith = 1'b1; w_dp_nowrite = 1'b1; end
            4'b1000: begin w_dp_alu = 2'b10; w_dp_nowrite = 1'b1; end
            default: begin w_dp_valid = 1'b0; w_dp_nowrite = 1'b1; end
        endcase
    end

    // State, flags and captured condition result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StFetch;
            r_flags  <= 4'b0000;
            r_condex <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == StDecode) begin
                r_condex <= w_cond_ok;
            end
            if (w_exec && w_s && r_condex && w_dp_valid) begin
                r_flags[3:2] <= ALUFlags[3:2];
                if (w_dp_arith) begin
                    r_flags[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    // Next-state logic and Moore control outputs
    always_comb begin
        w_next_state = StFetch;
        PCWrite      = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUControl   = 2'b00;
        ImmSrc       = 2'b00;
        RegSrc       = 2'b00;

        case (w_op)
            2'b01:   begin ImmSrc = 2'b01; RegSrc = 2'b10; end
            2'b10:   begin ImmSrc = 2'b10; RegSrc = 2'b01; end
            default: begin ImmSrc = 2'b00; RegSrc = 2'b00; end
        endcase

        case (r_state)
            StFetch: begin
                IRWrite      = 1'b1;
                PCWrite      = 1'b1;
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                w_next_state = StDecode;
            end
            StDecode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (w_op)
                    2'b00:   w_next_state = w_i ? StExecI : StExecR;
                    2'b01:   w_next_state = StMemAdr;
                    2'b10:   w_next_state = StBranch;
                    default: w_next_state = StFetch;
                endcase
            end
            StMemAdr: begin
                ALUSrcB      = 2'b01;
                w_next_state = w_s ? StMemRd : StMemWr;
            end
            StMemRd: begin
                AdrSrc       = 1'b1;
                w_next_state = StMemWb;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = r_condex;
                PCWrite   = r_condex & w_rd_pc;
            end
            StMemWr: begin
                AdrSrc   = 1'b1;
                MemWrite = r_condex;
            end
            StExecR: begin
                ALUControl   = w_dp_alu;
                w_next_state = StAluWb;
            end
            StExecI: begin
                ALUSrcB      = 2'b01;
                ALUControl   = w_dp_alu;
                w_next_state = StAluWb;
            end
            StAluWb: begin
                RegWrite = r_condex & ~w_dp_nowrite;
                PCWrite  = r_condex & ~w_dp_nowrite & w_rd_pc;
            end
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = r_condex;
            end
            default: w_next_state = StFetch;
        endcase
    end

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
- Control unit for a multicycle ARMv4-subset core in which instruction and data share one memory port, and one ALU also computes PC+4, PC+8 and branch targets.
- Sequences fetch, decode, execute, memory and writeback via a Moore FSM.
- Holds the NZCV flag register and gates all architectural writes by the instruction's condition field.
- Supports ADD, SUB, AND, ORR (with the S bit), CMP, TST, LDR, STR and B.

Parameters:
- None.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- Instr  input  20  Instr[31:12] from the instruction register: cond, op, funct, Rd
- ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register enable
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  result select: 00=ALUOut, 01=Data register, 10=ALUResult
- ALUSrcA  output  1  0=RD1, 1=PC
- ALUSrcB  output  2  00=RD2, 01=ExtImm, 10=constant 4
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  output  2  00 imm8, 01 imm12, 10 branch imm24
- RegSrc  output  2  [0]: RA1=15; [1]: RA2=Rd
- State  output  4  current FSM state, for debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Other encodings return to FETCH.
- FETCH:
  - AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1 (unconditional).
  - Next state: DECODE.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10 (PC+8 available on R15).
  - CondExR is captured at the clock edge leaving DECODE.
  - Next state by op = Instr[27:26]:
    - 00: EXECI if Instr[25], else EXECR
    - 01: MEMADR
    - 10: BRANCH
    - 11: FETCH, no writes
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00. Next: MEMRD if L (Instr[20]) is set, else MEMWR.
- MEMRD: AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondExR. Next: FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondExR. Next: FETCH.
- EXECR / EXECI:
  - ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI).
  - ALUControl from funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB), 1000 TST (AND). Any other value gives ADD with no writes.
  - Next state: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=CondExR & ~NoWrite, where NoWrite=1 for CMP and TST. Next: FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ResultSrc=10. Next: FETCH.
- PC writes outside FETCH:
  - PCWrite = CondExR in BRANCH.
  - PCWrite = CondExR in ALUWB or MEMWB when Rd=1111. RegWrite is still asserted in that case.
- ImmSrc and RegSrc are decoded from op in every state:
  - DP: ImmSrc=00, RegSrc=00
  - LDR/STR: ImmSrc=01, RegSrc=10
  - B: ImmSrc=10, RegSrc=01
- Flags:
  - NZ update at the edge ending EXECR/EXECI when S (Instr[20]) & CondExR.
  - CV update under the same condition, and only for ADD, SUB or CMP.
  - CMP and TST update flags only when the S bit is set.
  - Flags never change in any other state.
- Condition check uses the registered flags against cond (EQ through AL, per the ARM table). cond=1111 makes CondExR=0.
- Reset (asynchronous):
  - State=FETCH, Flags=0000, CondExR=0.
  - Outputs immediately take FETCH values: IRWrite=1, PCWrite=1, all other enables 0.
  - Reset asserted mid-instruction aborts it; no pending write occurs.
- Latency in cycles: B=3, DP=4, STR=4, LDR=5, undefined op=2.

Test Plan:
- Reset asserted during MEMRD -> State=0 without waiting for a clock edge; after release, the sequence is FETCH, DECODE.
- Instr=E2802005 (ADD R2,R0,#5) -> states 0,1,7,8,0; ALUControl=00 in EXECI; RegWrite=1 only in ALUWB; Flags unchanged.
- E5902060 (LDR) -> states 0,1,2,3,4; AdrSrc=1 in MEMRD; RegWrite=1 in MEMWB with ResultSrc=01. E5802064 (STR) -> MemWrite=1 only in MEMWR.
- E1570003 (CMP R7,R3) with ALUFlags=0100 -> RegWrite=0 in ALUWB; Flags=0100 after EXECR. Next instruction 0A000002 (BEQ) -> PCWrite=1 in BRANCH.
- With Z=0: 05802064 (STREQ) -> MemWrite=0. 00522003 (SUBSEQ) -> Flags unchanged, RegWrite=0.
- Op=11 instruction -> DECODE returns to FETCH; RegWrite, MemWrite and flag updates all 0; PCWrite only in FETCH.
